// File: rtl/regfile_xfer_ctrl_if.sv
// Request handshake plus register-bank strobe bundle for regfile_xfer_ctrl.
// slave = the controller; master = the requester/observer side driving requests and bus_in.
interface regfile_xfer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int IDXW  = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDXW-1:0]  req_src_a;
    logic [IDXW-1:0]  req_src_b;
    logic [IDXW-1:0]  req_dst;
    logic [WIDTH-1:0] bus_in;
    logic [NREGS-1:0] assert_bus;
    logic [NREGS-1:0] assert_lhs;
    logic [NREGS-1:0] assert_rhs;
    logic             alu_to_bus;
    logic [NREGS-1:0] load_bus;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             done_err;

    modport slave (
        input  req_valid, req_op, req_src_a, req_src_b, req_dst, bus_in,
        output req_ready, assert_bus, assert_lhs, assert_rhs, alu_to_bus,
               load_bus, rd_data, done, done_err
    );

    modport master (
        output req_valid, req_op, req_src_a, req_src_b, req_dst, bus_in,
        input  req_ready, assert_bus, assert_lhs, assert_rhs, alu_to_bus,
               load_bus, rd_data, done, done_err
    );
endinterface

// File: rtl/regfile_xfer_ctrl.sv
// Sequences MOV / ALU / READ transfers over a register_gp bank using one-hot strobes.
// IDLE -> DRIVE (SETTLE_CYCLES) -> COMMIT -> IDLE; all strobes are registered.
module regfile_xfer_ctrl #(
    parameter int WIDTH         = 8,
    parameter int NREGS         = 4,
    parameter int IDXW          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    regfile_xfer_ctrl_if.slave xfer
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [1:0]    OP_MOV      = 2'b00;
    localparam logic [1:0]    OP_ALU      = 2'b01;
    localparam logic [1:0]    OP_READ     = 2'b10;
    localparam logic [IDXW:0] NREGS_W     = NREGS[IDXW:0];
    localparam logic [3:0]    SETTLE_W    = SETTLE_CYCLES[3:0];
    localparam logic [3:0]    SETTLE_LAST = (SETTLE_CYCLES > 0) ? (SETTLE_W - 4'd1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [IDXW-1:0]   a_q, a_d, b_q, b_d, dst_q, dst_d;
    logic [NREGS-1:0]  bus_q, bus_d, lhs_q, lhs_d, rhs_q, rhs_d, load_q, load_d;
    logic              alu_q, alu_d;
    logic              done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic              req_ok_s;

    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        return ({1'b0, idx} < NREGS_W);
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NREGS-1:0] v;
        v = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
            else                v[i] = 1'b0;
        end
        return v;
    endfunction

    // Request legality: every index the op uses must name an existing register.
    always_comb begin
        req_ok_s = 1'b0;
        case (xfer.req_op)
            OP_MOV:  req_ok_s = idx_ok(xfer.req_src_a) && idx_ok(xfer.req_dst);
            OP_ALU:  req_ok_s = idx_ok(xfer.req_src_a) && idx_ok(xfer.req_src_b) && idx_ok(xfer.req_dst);
            OP_READ: req_ok_s = idx_ok(xfer.req_src_a);
            default: req_ok_s = 1'b0;
        endcase
    end

    // Next-state, field latching, done/err and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (xfer.req_valid) begin
                    if (req_ok_s) begin
                        op_d    = xfer.req_op;
                        a_d     = xfer.req_src_a;
                        b_d     = xfer.req_src_b;
                        dst_d   = xfer.req_dst;
                        cnt_d   = SETTLE_LAST;
                        state_d = (SETTLE_CYCLES == 0) ? S_COMMIT : S_DRIVE;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) state_d = S_COMMIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_READ) rd_d = xfer.bus_in;
                else                 rd_d = rd_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so they appear the cycle after accept.
    always_comb begin
        bus_d  = {NREGS{1'b0}};
        lhs_d  = {NREGS{1'b0}};
        rhs_d  = {NREGS{1'b0}};
        load_d = {NREGS{1'b0}};
        alu_d  = 1'b0;
        if (state_d != S_IDLE) begin
            case (op_d)
                OP_MOV: begin
                    bus_d = onehot(a_d);
                    if (state_d == S_COMMIT) load_d = onehot(dst_d);
                    else                     load_d = {NREGS{1'b0}};
                end
                OP_ALU: begin
                    lhs_d = onehot(a_d);
                    rhs_d = onehot(b_d);
                    alu_d = 1'b1;
                    if (state_d == S_COMMIT) load_d = onehot(dst_d);
                    else                     load_d = {NREGS{1'b0}};
                end
                OP_READ: bus_d = onehot(a_d);
                default: bus_d = {NREGS{1'b0}};
            endcase
        end else begin
            bus_d = {NREGS{1'b0}};
        end
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'b00;
            a_q     <= {IDXW{1'b0}};
            b_q     <= {IDXW{1'b0}};
            dst_q   <= {IDXW{1'b0}};
            bus_q   <= {NREGS{1'b0}};
            lhs_q   <= {NREGS{1'b0}};
            rhs_q   <= {NREGS{1'b0}};
            load_q  <= {NREGS{1'b0}};
            alu_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            bus_q   <= bus_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            load_q  <= load_d;
            alu_q   <= alu_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign xfer.req_ready  = (state_q == S_IDLE);
    assign xfer.assert_bus = bus_q;
    assign xfer.assert_lhs = lhs_q;
    assign xfer.assert_rhs = rhs_q;
    assign xfer.alu_to_bus = alu_q;
    assign xfer.load_bus   = load_q;
    assign xfer.rd_data    = rd_q;
    assign xfer.done       = done_q;
    assign xfer.done_err   = err_q;
endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Scoreboard bench: dut0 (NREGS=4, SETTLE=1) and dut1 (NREGS=3, SETTLE=0); a negedge
// monitor accumulates strobe activity per transfer and checks it against queued expectations.
module tb_regfile_xfer_ctrl;
    typedef struct {
        logic       err;
        logic [7:0] rd;
        logic [3:0] bus, lhs, rhs, load;
        logic       alu;
        int         act;
        int         ldc;
        int         lat;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_xfer_ctrl_if #(.WIDTH(8), .NREGS(4), .IDXW(2)) if0 ();
    regfile_xfer_ctrl_if #(.WIDTH(8), .NREGS(3), .IDXW(2)) if1 ();

    regfile_xfer_ctrl #(.WIDTH(8), .NREGS(4), .IDXW(2), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .reset_n(rst_n), .xfer(if0.slave));
    regfile_xfer_ctrl #(.WIDTH(8), .NREGS(3), .IDXW(2), .SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .reset_n(rst_n), .xfer(if1.slave));

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [3:0] acc_bus[2], acc_lhs[2], acc_rhs[2], acc_load[2];
    logic       acc_alu[2];
    int         act_cnt[2], ld_cnt[2], acc_cyc[2], last_done[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [7:0] rd, input logic [3:0] bus,
                                input logic [3:0] lhs, input logic [3:0] rhs, input logic [3:0] load,
                                input logic alu, input int act, input int ldc, input int lat, input int gap);
        exp_t e;
        e.err = err; e.rd = rd; e.bus = bus; e.lhs = lhs; e.rhs = rhs; e.load = load;
        e.alu = alu; e.act = act; e.ldc = ldc; e.lat = lat; e.gap = gap;
        return e;
    endfunction

    task automatic clear_acc(input int id);
        acc_bus[id] = 4'd0; acc_lhs[id] = 4'd0; acc_rhs[id] = 4'd0; acc_load[id] = 4'd0;
        acc_alu[id] = 1'b0; act_cnt[id] = 0; ld_cnt[id] = 0;
    endtask

    task automatic mon(input int id, input logic valid, input logic ready, input logic done,
                       input logic err, input logic [3:0] ab, input logic [3:0] al, input logic [3:0] ar,
                       input logic [3:0] ld, input logic alu, input logic [7:0] rd);
        exp_t e;
        bit   have;
        chk($sformatf("bus_driver_onehot%0d", id), 32'(($countones(ab) + int'(alu)) <= 1), 32'd1);
        chk($sformatf("load_onehot%0d", id), 32'($onehot0(ld)), 32'd1);
        chk($sformatf("lhs_rhs_onehot%0d", id), 32'($onehot0(al) && $onehot0(ar)), 32'd1);
        if (ready) chk($sformatf("idle_quiet%0d", id), 32'({ab, al, ar, ld, alu}), 32'd0);
        if ((ab | al | ar | ld) != 4'd0 || alu) act_cnt[id]++;
        if (ld != 4'd0) ld_cnt[id]++;
        acc_bus[id] |= ab; acc_lhs[id] |= al; acc_rhs[id] |= ar; acc_load[id] |= ld;
        acc_alu[id] |= alu;
        if (done) begin
            have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                chk($sformatf("unexpected_done%0d", id), 32'd1, 32'd0);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                chk($sformatf("done_err%0d", id), 32'(err), 32'(e.err));
                chk($sformatf("rd_data%0d", id), 32'(rd), 32'(e.rd));
                chk($sformatf("assert_bus%0d", id), 32'(acc_bus[id]), 32'(e.bus));
                chk($sformatf("assert_lhs%0d", id), 32'(acc_lhs[id]), 32'(e.lhs));
                chk($sformatf("assert_rhs%0d", id), 32'(acc_rhs[id]), 32'(e.rhs));
                chk($sformatf("load_bus%0d", id), 32'(acc_load[id]), 32'(e.load));
                chk($sformatf("alu_to_bus%0d", id), 32'(acc_alu[id]), 32'(e.alu));
                chk($sformatf("strobe_cycles%0d", id), 32'(act_cnt[id]), 32'(e.act));
                chk($sformatf("load_cycles%0d", id), 32'(ld_cnt[id]), 32'(e.ldc));
                chk($sformatf("latency%0d", id), 32'(cyc - acc_cyc[id]), 32'(e.lat));
                if (e.gap != 0) chk($sformatf("done_gap%0d", id), 32'(cyc - last_done[id]), 32'(e.gap));
            end
            clear_acc(id);
            last_done[id] = cyc;
        end
        if (valid && ready) acc_cyc[id] = cyc;
    endtask

    // Monitor: samples both DUTs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.req_valid, if0.req_ready, if0.done, if0.done_err, if0.assert_bus,
                if0.assert_lhs, if0.assert_rhs, if0.load_bus, if0.alu_to_bus, if0.rd_data);
            mon(1, if1.req_valid, if1.req_ready, if1.done, if1.done_err, {1'b0, if1.assert_bus},
                {1'b0, if1.assert_lhs}, {1'b0, if1.assert_rhs}, {1'b0, if1.load_bus},
                if1.alu_to_bus, if1.rd_data);
        end else begin
            clear_acc(0);
            clear_acc(1);
        end
    end

    task automatic issue(input int id, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] dst, input exp_t e, input bit push, input bit hold);
        bit rdy;
        int n;
        if (push) begin
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        if (id == 0) begin
            if0.req_op = op; if0.req_src_a = a; if0.req_src_b = b; if0.req_dst = dst; if0.req_valid = 1'b1;
        end else begin
            if1.req_op = op; if1.req_src_a = a; if1.req_src_b = b; if1.req_dst = dst; if1.req_valid = 1'b1;
        end
        rdy = 1'b0;
        for (n = 0; n < 50 && !rdy; n++) begin
            @(negedge clk);
            rdy = (id == 0) ? if0.req_ready : if1.req_ready;
        end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            if (id == 0) if0.req_valid = 1'b0;
            else         if1.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 100 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        exp_t z;
        z = mk(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 0, 0);
        clear_acc(0); clear_acc(1);
        last_done[0] = 0; last_done[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        if0.req_valid = 1'b0; if0.req_op = 2'b00; if0.req_src_a = 2'd0; if0.req_src_b = 2'd0;
        if0.req_dst = 2'd0; if0.bus_in = 8'h00;
        if1.req_valid = 1'b0; if1.req_op = 2'b00; if1.req_src_a = 2'd0; if1.req_src_b = 2'd0;
        if1.req_dst = 2'd0; if1.bus_in = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(if0.req_ready), 32'd1);
        chk("reset_strobes", 32'({if0.assert_bus, if0.assert_lhs, if0.assert_rhs, if0.load_bus, if0.alu_to_bus}), 32'd0);
        chk("reset_done", 32'({if0.done, if0.done_err}), 32'd0);
        chk("reset_rd_data", 32'(if0.rd_data), 32'd0);
        @(posedge clk); #1;

        // dut0: NREGS=4, SETTLE=1 -> 2 strobe cycles, latency 3
        issue(0, 2'b00, 2'd1, 2'd0, 2'd3, mk(1'b0, 8'h00, 4'b0010, 4'd0, 4'd0, 4'b1000, 1'b0, 2, 1, 3, 0), 1'b1, 1'b0);
        drain();
        issue(0, 2'b01, 2'd0, 2'd2, 2'd1, mk(1'b0, 8'h00, 4'd0, 4'b0001, 4'b0100, 4'b0010, 1'b1, 2, 1, 3, 0), 1'b1, 1'b0);
        drain();
        if0.bus_in = 8'hA5;
        issue(0, 2'b10, 2'd2, 2'd0, 2'd0, mk(1'b0, 8'hA5, 4'b0100, 4'd0, 4'd0, 4'd0, 1'b0, 2, 0, 3, 0), 1'b1, 1'b0);
        drain();
        issue(0, 2'b11, 2'd1, 2'd2, 2'd3, mk(1'b1, 8'hA5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 1, 0), 1'b1, 1'b0);
        drain();
        issue(0, 2'b00, 2'd3, 2'd0, 2'd0, mk(1'b0, 8'hA5, 4'b1000, 4'd0, 4'd0, 4'b0001, 1'b0, 2, 1, 3, 0), 1'b1, 1'b0);
        drain();
        issue(0, 2'b01, 2'd2, 2'd2, 2'd2, mk(1'b0, 8'hA5, 4'd0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2, 1, 3, 0), 1'b1, 1'b0);
        drain();
        if0.bus_in = 8'h3C;
        issue(0, 2'b10, 2'd0, 2'd3, 2'd3, mk(1'b0, 8'h3C, 4'b0001, 4'd0, 4'd0, 4'd0, 1'b0, 2, 0, 3, 0), 1'b1, 1'b0);
        drain();

        // dut1: NREGS=3, SETTLE=0 -> index 3 rejected, 1 strobe cycle, latency 2
        issue(1, 2'b00, 2'd0, 2'd0, 2'd3, mk(1'b1, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 1, 0), 1'b1, 1'b0);
        drain();
        issue(1, 2'b01, 2'd3, 2'd0, 2'd1, mk(1'b1, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 1, 0), 1'b1, 1'b0);
        drain();
        issue(1, 2'b10, 2'd3, 2'd0, 2'd0, mk(1'b1, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 1, 0), 1'b1, 1'b0);
        drain();
        issue(1, 2'b00, 2'd0, 2'd0, 2'd1, mk(1'b0, 8'h00, 4'b0001, 4'd0, 4'd0, 4'b0010, 1'b0, 1, 1, 2, 0), 1'b1, 1'b1);
        issue(1, 2'b00, 2'd1, 2'd0, 2'd2, mk(1'b0, 8'h00, 4'b0010, 4'd0, 4'd0, 4'b0100, 1'b0, 1, 1, 2, 2), 1'b1, 1'b1);
        issue(1, 2'b00, 2'd2, 2'd0, 2'd0, mk(1'b0, 8'h00, 4'b0100, 4'd0, 4'd0, 4'b0001, 1'b0, 1, 1, 2, 2), 1'b1, 1'b0);
        drain();

        // Reset during COMMIT of a MOV on dut0: strobes clear at once, no completion
        issue(0, 2'b00, 2'd1, 2'd0, 2'd3, z, 1'b0, 1'b0);
        for (n = 0; n < 20 && if0.load_bus == 4'd0; n++) @(negedge clk);
        chk("reached_commit", 32'(if0.load_bus), 32'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_strobes", 32'({if0.assert_bus, if0.assert_lhs, if0.assert_rhs, if0.load_bus, if0.alu_to_bus}), 32'd0);
        chk("async_reset_done", 32'({if0.done, if0.done_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(if0.req_ready), 32'd1);
        chk("post_reset_rd_data", 32'(if0.rd_data), 32'd0);
        @(posedge clk); #1;
        issue(0, 2'b00, 2'd0, 2'd0, 2'd2, mk(1'b0, 8'h00, 4'b0001, 4'd0, 4'd0, 4'b0100, 1'b0, 2, 1, 3, 0), 1'b1, 1'b0);
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
